// File: rtl/la_capture_core.sv
// Embedded logic-analyzer capture core: circular sample buffer, mask/value trigger and pre-trigger.
// The optional storage qualifier input qual_i is enabled by defining LA_CAPTURE_QUAL_EN.
module la_capture_core #(
  parameter int unsigned DATA_W = 29,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] probe_i,
`ifdef LA_CAPTURE_QUAL_EN
  input  logic              qual_i,
`endif
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  typedef enum logic [2:0] {StIdle, StFill, StWait, StPost, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                prev_match_q, prev_match_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                qual;
  logic                match;
  logic                fire;
  logic                we;
  logic [ADDR_W-1:0]   post_cnt;
  logic [ADDR_W-1:0]   rd_phys;

`ifdef LA_CAPTURE_QUAL_EN
  assign qual = qual_i;
`else
  assign qual = 1'b1;
`endif

  assign match    = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  assign post_cnt = ADDR_W'(DEPTH - 1) - pre_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    trig_addr_d  = trig_addr_q;
    prev_match_d = prev_match_q;
    we           = 1'b0;
    fire         = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_i) begin
            pre_d        = pretrig_i;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            prev_match_d = 1'b0;
            state_d      = (pretrig_i != '0) ? StFill : StWait;
          end
        end
        StFill: begin
          if (qual) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_d == pre_q) state_d = StWait;
          end
        end
        StWait: begin
          if (qual) begin
            we           = 1'b1;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            prev_match_d = match;
            case (trig_mode_i)
              2'b01:   fire = match & ~prev_match_q;
              2'b10:   fire = 1'b1;
              default: fire = match;
            endcase
            if (fire) begin
              trig_addr_d = wr_ptr_q;
              cnt_d       = post_cnt;
              state_d     = (post_cnt == '0) ? StDone : StPost;
            end
          end
        end
        StPost: begin
          if (qual) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == ADDR_W'(1)) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Oldest stored sample sits PRE entries before the trigger sample.
  assign rd_phys = trig_addr_q - pre_q + rd_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      trig_addr_q  <= '0;
      prev_match_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      trig_addr_q  <= trig_addr_d;
      prev_match_q <= prev_match_d;
      rd_data_q    <= mem_q[rd_phys];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr_q] <= probe_i;
  end

  assign rd_data_o   = rd_data_q;
  assign trig_addr_o = trig_addr_q;
  assign armed_o     = (state_q == StFill) || (state_q == StWait) || (state_q == StPost);
  assign triggered_o = (state_q == StPost) || (state_q == StDone);
  assign done_o      = (state_q == StDone);

endmodule
